// File: rtl/mem_access_stage_if.sv
// ============================================================================
// Module      : mem_access_stage_if
// Description : EX/MEM-side bus into the memory stage and its result/fault outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadData;
    logic        FaultM;
    logic        FaultValid;
    logic [31:0] FaultAddr;
    logic [1:0]  FaultCause;
    logic [31:0] StoreCount;

    modport master (
        output MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM,
        input  ReadData, FaultM, FaultValid, FaultAddr, FaultCause, StoreCount
    );

    modport slave (
        input  MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM,
        output ReadData, FaultM, FaultValid, FaultAddr, FaultCause, StoreCount
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : RV32I MEM stage - data RAM, load formatting, store merge, fault latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave bus
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
    localparam logic [1:0] c_CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] c_CAUSE_RANGE = 2'b10;
    localparam logic [1:0] c_CAUSE_F3    = 2'b11;

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic             r_fault_valid;
    logic [31:0]      r_fault_addr;
    logic [1:0]       r_fault_cause;
    logic [31:0]      r_store_count;

    logic             w_access;
    logic             w_legal_store;
    logic             w_legal_load;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_fault;
    logic [1:0]       w_cause;
    logic [1:0]       w_offset;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_read_data;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_wr_data;
    logic             w_commit;

    assign w_access = bus.MemReadM | bus.MemWriteM;
    assign w_index  = bus.ALUResultM[IDX_W+1:2];
    assign w_offset = bus.ALUResultM[1:0];

    assign w_legal_store = (bus.funct3M == c_F3_B) || (bus.funct3M == c_F3_H) ||
                           (bus.funct3M == c_F3_W);
    assign w_legal_load  = w_legal_store || (bus.funct3M == c_F3_BU) ||
                           (bus.funct3M == c_F3_HU);

    // A combined read+write is a store, so only store codes are legal then.
    assign w_illegal      = w_access & ~(bus.MemWriteM ? w_legal_store : w_legal_load);
    assign w_misaligned   = w_access &
                            (((bus.funct3M[1:0] == 2'b01) & w_offset[0]) |
                             ((bus.funct3M[1:0] == 2'b10) & (w_offset != 2'b00)));
    assign w_out_of_range = w_access & (|bus.ALUResultM[31:IDX_W+2]);
    assign w_fault        = w_illegal | w_misaligned | w_out_of_range;

    always_comb begin
        w_cause = c_CAUSE_NONE;
        if (w_illegal) begin
            w_cause = c_CAUSE_F3;
        end else if (w_misaligned) begin
            w_cause = c_CAUSE_ALIGN;
        end else if (w_out_of_range) begin
            w_cause = c_CAUSE_RANGE;
        end
    end

    // Asynchronous read gives the pre-edge word, i.e. read-before-write on read+write.
    assign w_word = r_mem[w_index];
    assign w_byte = w_word[{w_offset, 3'b000} +: 8];
    assign w_half = w_offset[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_read_data = '0;
        if (!rst && bus.MemReadM && !w_fault) begin
            case (bus.funct3M)
                c_F3_B:  w_read_data = {{24{w_byte[7]}}, w_byte};
                c_F3_H:  w_read_data = {{16{w_half[15]}}, w_half};
                c_F3_W:  w_read_data = w_word;
                c_F3_BU: w_read_data = {24'h0, w_byte};
                c_F3_HU: w_read_data = {16'h0, w_half};
                default: w_read_data = '0;
            endcase
        end
    end

    always_comb begin
        w_byte_en = 4'b1111;
        w_wr_data = bus.WriteDataM;
        case (bus.funct3M[1:0])
            2'b00: begin
                w_byte_en = 4'b0001 << w_offset;
                w_wr_data = {4{bus.WriteDataM[7:0]}};
            end
            2'b01: begin
                w_byte_en = w_offset[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{bus.WriteDataM[15:0]}};
            end
            default: begin
                w_byte_en = 4'b1111;
                w_wr_data = bus.WriteDataM;
            end
        endcase
    end

    assign w_commit = bus.MemWriteM & ~w_fault & ~rst;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_cause <= c_CAUSE_NONE;
            r_store_count <= '0;
        end else begin
            if (w_fault && !r_fault_valid) begin
                r_fault_valid <= 1'b1;
                r_fault_addr  <= bus.ALUResultM;
                r_fault_cause <= w_cause;
            end
            if (w_commit) begin
                r_store_count <= r_store_count + 32'd1;
            end
        end
    end

    assign bus.ReadData   = w_read_data;
    assign bus.FaultM     = w_fault;
    assign bus.FaultValid = r_fault_valid;
    assign bus.FaultAddr  = r_fault_addr;
    assign bus.FaultCause = r_fault_cause;
    assign bus.StoreCount = r_store_count;

endmodule

`default_nettype wire
